inv_ps_iter: RTL

//  Iterative inverse of the Ascon substitution layer (p_S^-1) on a 320-bit type_state (5 x 64-bit words).

---
 rtl/inv_ps_iter.sv | 114 +++++++++++
 1 files changed

// File: rtl/inv_ps_iter.sv
// Iterative inverse Ascon substitution layer: LANES bit-columns per clock over a 5x64 state.
// Latency 64/LANES+1 edges from accept to valid_o; holds result in DONE while ready_i=0, ready_o only in IDLE.
module inv_ps_iter #(
    parameter int LANES = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [4:0][63:0]  state_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [4:0][63:0]  state_o,
    output logic              busy_o
);

    localparam int NGRP  = 64 / LANES;
    localparam int CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 &&
            LANES != 16 && LANES != 32 && LANES != 64) begin : g_bad_lanes
            $error("inv_ps_iter: LANES must be a power of two between 1 and 64");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_t;

    fsm_t                fsm_q, fsm_d;
    logic [CNT_W-1:0]    col_cnt_q, col_cnt_d;
    logic [4:0][63:0]    work_q, work_d;

    // x is {w0,w1,w2,w3,w4} of one column, w0 in the MSB.
    function automatic logic [4:0] inv_sbox(input logic [4:0] x);
        logic [4:0] y;
        case (x)
            5'h00: y = 5'h14;  5'h01: y = 5'h1a;  5'h02: y = 5'h07;  5'h03: y = 5'h0d;
            5'h04: y = 5'h00;  5'h05: y = 5'h09;  5'h06: y = 5'h0e;  5'h07: y = 5'h12;
            5'h08: y = 5'h0a;  5'h09: y = 5'h06;  5'h0a: y = 5'h1d;  5'h0b: y = 5'h01;
            5'h0c: y = 5'h19;  5'h0d: y = 5'h15;  5'h0e: y = 5'h13;  5'h0f: y = 5'h1e;
            5'h10: y = 5'h18;  5'h11: y = 5'h16;  5'h12: y = 5'h0b;  5'h13: y = 5'h11;
            5'h14: y = 5'h03;  5'h15: y = 5'h05;  5'h16: y = 5'h1c;  5'h17: y = 5'h1f;
            5'h18: y = 5'h17;  5'h19: y = 5'h1b;  5'h1a: y = 5'h04;  5'h1b: y = 5'h08;
            5'h1c: y = 5'h0f;  5'h1d: y = 5'h0c;  5'h1e: y = 5'h10;  default: y = 5'h02;
        endcase
        return y;
    endfunction

    always_comb begin
        fsm_d     = fsm_q;
        col_cnt_d = col_cnt_q;
        work_d    = work_q;
        unique case (fsm_q)
            S_IDLE: begin
                if (valid_i) begin
                    work_d    = state_i;
                    col_cnt_d = '0;
                    fsm_d     = S_RUN;
                end
            end
            S_RUN: begin
                for (int l = 0; l < LANES; l++) begin : g_lane
                    logic [5:0] col;
                    logic [4:0] x;
                    logic [4:0] y;
                    col = 6'(int'(col_cnt_q) * LANES + l);
                    x   = {work_q[0][col], work_q[1][col], work_q[2][col],
                           work_q[3][col], work_q[4][col]};
                    y   = inv_sbox(x);
                    work_d[0][col] = y[4];
                    work_d[1][col] = y[3];
                    work_d[2][col] = y[2];
                    work_d[3][col] = y[1];
                    work_d[4][col] = y[0];
                end
                if (col_cnt_q == CNT_W'(NGRP - 1)) begin
                    col_cnt_d = '0;
                    fsm_d     = S_DONE;
                end else begin
                    col_cnt_d = col_cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q     <= S_IDLE;
            col_cnt_q <= '0;
            work_q    <= '0;
        end else begin
            fsm_q     <= fsm_d;
            col_cnt_q <= col_cnt_d;
            work_q    <= work_d;
        end
    end

    // Outputs decode registered state only, so no input reaches them combinationally.
    assign ready_o = (fsm_q == S_IDLE);
    assign busy_o  = (fsm_q == S_RUN);
    assign valid_o = (fsm_q == S_DONE);
    assign state_o = work_q;

endmodule
